// File: rtl/forward_hazard_unit.sv
// Operand forwarding from a short retired-result history, plus a small FSM
// that inserts store stalls and branch flushes and selects the RAM address.
module forward_hazard_unit #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int FWD_DEPTH    = 2,
    parameter int STORE_STALL  = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ex_src,
    input  logic [1:0]        ex_mode,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_we,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              store,
    input  logic              branch,
    input  logic [DATA_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_wr_addr,
    output logic [1:0]        mode_out,
    output logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] ram_addr,
    output logic              stall,
    output logic              flush
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] LP_STORE_CNT = 4'(STORE_STALL - 1);
    localparam logic [3:0] LP_FLUSH_CNT = 4'(FLUSH_CYCLES - 1);
    localparam logic [1:0] LP_MODE_REG  = 2'b10;
    localparam logic [1:0] LP_MODE_FWD  = 2'b11;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_stall;
    logic              r_flush;

    logic              r_valid [FWD_DEPTH];
    logic [REG_AW-1:0] r_dst   [FWD_DEPTH];
    logic [DATA_W-1:0] r_data  [FWD_DEPTH];

    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic              w_use_fwd;

    // Entry 0 is the youngest; results retired during a flush are squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_dst[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else if (!r_stall) begin
            r_valid[0] <= ex_we & ~r_flush;
            r_dst[0]   <= ex_dst;
            r_data[0]  <= alu_result;
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_dst[k]   <= r_dst[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_stall <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (branch) begin
                        r_state <= FLUSH;
                        r_cnt   <= LP_FLUSH_CNT;
                        r_flush <= 1'b1;
                        r_stall <= 1'b0;
                    end else if (store) begin
                        r_state <= STALL;
                        r_cnt   <= LP_STORE_CNT;
                        r_stall <= 1'b1;
                        r_flush <= 1'b0;
                    end
                end
                STALL: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= IDLE;
                        r_stall <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    // A branch taken mid-flush restarts the full flush window.
                    if (branch) begin
                        r_cnt <= LP_FLUSH_CNT;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= IDLE;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                    r_stall <= 1'b0;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_dst[i] == ex_src)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[i];
            end
        end
    end

    assign w_use_fwd = !rst && (ex_mode == LP_MODE_REG) && (ex_src != '0) && w_hit;

    assign mode_out = w_use_fwd ? LP_MODE_FWD : ex_mode;
    assign fwd_data = w_use_fwd ? w_hit_data : '0;

    always_comb begin
        ram_addr = ram_rd_addr;
        if (!rst) begin
            if (r_state == STALL || (r_state == IDLE && store)) begin
                ram_addr = ram_wr_addr;
            end
        end
    end

    assign stall = r_stall;
    assign flush = r_flush;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding priority, store stalls,
// branch flushes, store/branch collision and reset in the middle of a stall.
module tb_forward_hazard_unit;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [31:0] RD_ADDR = 32'h0000_1000;
    localparam logic [31:0] WR_ADDR = 32'h0000_2000;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] ex_src;
    logic [1:0]        ex_mode;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_we;
    logic [DATA_W-1:0] alu_result;
    logic              store;
    logic              branch;
    logic [DATA_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_wr_addr;
    logic [1:0]        mode_out;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] ram_addr;
    logic              stall;
    logic              flush;

    int checks = 0;
    int errors = 0;

    forward_hazard_unit #(
        .DATA_W      (DATA_W),
        .REG_AW      (REG_AW),
        .FWD_DEPTH   (2),
        .STORE_STALL (3),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_src     (ex_src),
        .ex_mode    (ex_mode),
        .ex_dst     (ex_dst),
        .ex_we      (ex_we),
        .alu_result (alu_result),
        .store      (store),
        .branch     (branch),
        .ram_rd_addr(ram_rd_addr),
        .ram_wr_addr(ram_wr_addr),
        .mode_out   (mode_out),
        .fwd_data   (fwd_data),
        .ram_addr   (ram_addr),
        .stall      (stall),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [4:0] src, input logic [1:0] mode,
                                 input logic [4:0] dst, input logic we,
                                 input logic [31:0] alu, input logic st,
                                 input logic br);
        ex_src     = src;
        ex_mode    = mode;
        ex_dst     = dst;
        ex_we      = we;
        alu_result = alu;
        store      = st;
        branch     = br;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ram_rd_addr = RD_ADDR;
        ram_wr_addr = WR_ADDR;
        rst = 1'b1;
        applyStimulus(5'd0, 2'b01, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_mode", {30'd0, mode_out}, 32'd1);
        checkOutput("rst_fwd", fwd_data, 32'd0);
        checkOutput("rst_ramaddr", ram_addr, RD_ADDR);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // Write r3 then read it back-to-back, then from the older slot.
        applyStimulus(5'd0, 2'b00, 5'd3, 1'b1, 32'h55, 1'b0, 1'b0);
        #3;
        checkOutput("c1_stall", {31'd0, stall}, 32'd0);
        checkOutput("c1_mode", {30'd0, mode_out}, 32'd0);
        checkOutput("c1_ramaddr", ram_addr, RD_ADDR);
        nextCycle();
        applyStimulus(5'd3, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("b2b_mode", {30'd0, mode_out}, 32'd3);
        checkOutput("b2b_fwd", fwd_data, 32'h55);
        nextCycle();
        applyStimulus(5'd3, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("older_mode", {30'd0, mode_out}, 32'd3);
        checkOutput("older_fwd", fwd_data, 32'h55);
        nextCycle();
        applyStimulus(5'd3, 2'b10, 5'd4, 1'b1, 32'h11, 1'b0, 1'b0);
        #3;
        checkOutput("aged_mode", {30'd0, mode_out}, 32'd2);
        checkOutput("aged_fwd", fwd_data, 32'd0);

        // Youngest-wins with two writes of r4.
        nextCycle();
        applyStimulus(5'd4, 2'b10, 5'd4, 1'b1, 32'h22, 1'b0, 1'b0);
        #3;
        checkOutput("r4_first_fwd", fwd_data, 32'h11);
        nextCycle();
        applyStimulus(5'd4, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("youngest_mode", {30'd0, mode_out}, 32'd3);
        checkOutput("youngest_fwd", fwd_data, 32'h22);
        nextCycle();
        applyStimulus(5'd4, 2'b01, 5'd0, 1'b1, 32'h99, 1'b0, 1'b0);
        #3;
        checkOutput("direct_mode", {30'd0, mode_out}, 32'd1);
        checkOutput("direct_fwd", fwd_data, 32'd0);
        nextCycle();
        applyStimulus(5'd0, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("r0_mode", {30'd0, mode_out}, 32'd2);
        checkOutput("r0_fwd", fwd_data, 32'd0);

        // Store stall: history must stay frozen for three stall cycles.
        nextCycle();
        applyStimulus(5'd0, 2'b00, 5'd7, 1'b1, 32'h77, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd7, 2'b10, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        #3;
        checkOutput("st_idle_stall", {31'd0, stall}, 32'd0);
        checkOutput("st_idle_ramaddr", ram_addr, WR_ADDR);
        checkOutput("st_idle_fwd", fwd_data, 32'h77);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(5'd7, 2'b10, 5'd9, 1'b1, 32'hDEAD, 1'b0, 1'b0);
            #3;
            checkOutput($sformatf("st%0d_stall", i), {31'd0, stall}, 32'd1);
            checkOutput($sformatf("st%0d_flush", i), {31'd0, flush}, 32'd0);
            checkOutput($sformatf("st%0d_ramaddr", i), ram_addr, WR_ADDR);
            checkOutput($sformatf("st%0d_fwd", i), fwd_data, 32'h77);
        end
        nextCycle();
        applyStimulus(5'd9, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("st_end_stall", {31'd0, stall}, 32'd0);
        checkOutput("st_end_ramaddr", ram_addr, RD_ADDR);
        checkOutput("st_frozen_mode", {30'd0, mode_out}, 32'd2);

        // Branch at t0 and t1: flush high t1..t3, squashed writes not forwarded.
        nextCycle();
        applyStimulus(5'd0, 2'b00, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        #3;
        checkOutput("br_t0_flush", {31'd0, flush}, 32'd0);
        nextCycle();
        applyStimulus(5'd0, 2'b00, 5'd5, 1'b1, 32'h5A, 1'b0, 1'b1);
        #3;
        checkOutput("br_t1_flush", {31'd0, flush}, 32'd1);
        checkOutput("br_t1_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(5'd5, 2'b10, 5'd5, 1'b1, 32'h5B, 1'b0, 1'b0);
        #3;
        checkOutput("br_t2_flush", {31'd0, flush}, 32'd1);
        checkOutput("br_t2_mode", {30'd0, mode_out}, 32'd2);
        nextCycle();
        applyStimulus(5'd5, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("br_t3_flush", {31'd0, flush}, 32'd1);
        checkOutput("br_t3_fwd", fwd_data, 32'd0);
        nextCycle();
        applyStimulus(5'd5, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("br_t4_flush", {31'd0, flush}, 32'd0);
        checkOutput("br_t4_mode", {30'd0, mode_out}, 32'd2);

        // Store and branch together: flush wins, stall never rises.
        nextCycle();
        applyStimulus(5'd0, 2'b00, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(5'd0, 2'b00, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
            #3;
            checkOutput($sformatf("sb%0d_flush", i), {31'd0, flush}, 32'd1);
            checkOutput($sformatf("sb%0d_stall", i), {31'd0, stall}, 32'd0);
            checkOutput($sformatf("sb%0d_ramaddr", i), ram_addr, RD_ADDR);
        end
        nextCycle();
        #3;
        checkOutput("sb_end_flush", {31'd0, flush}, 32'd0);
        checkOutput("sb_end_stall", {31'd0, stall}, 32'd0);

        // Reset during the second stall cycle.
        nextCycle();
        applyStimulus(5'd0, 2'b00, 5'd6, 1'b1, 32'h66, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(5'd6, 2'b10, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("rs_s1_stall", {31'd0, stall}, 32'd1);
        checkOutput("rs_s1_fwd", fwd_data, 32'h66);
        nextCycle();
        rst = 1'b1;
        #3;
        checkOutput("rs_async_stall", {31'd0, stall}, 32'd0);
        checkOutput("rs_async_mode", {30'd0, mode_out}, 32'd2);
        checkOutput("rs_async_fwd", fwd_data, 32'd0);
        checkOutput("rs_async_ramaddr", ram_addr, RD_ADDR);
        nextCycle();
        rst = 1'b0;
        #3;
        checkOutput("rs_rel_mode", {30'd0, mode_out}, 32'd2);
        checkOutput("rs_rel_fwd", fwd_data, 32'd0);
        checkOutput("rs_rel_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        #3;
        checkOutput("rs_after_stall", {31'd0, stall}, 32'd0);
        checkOutput("rs_after_flush", {31'd0, flush}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: ALU/RAM-address/forward data width.
REQ-002 SHALL provide parameter REG_AW, default 5: register-index width.
REQ-003 SHALL provide parameter FWD_DEPTH, default 2, legal range 1-4: retired-result history entries available for forwarding.
REQ-004 SHALL provide parameter STORE_STALL, default 1, legal range 1-15: stall cycles per store.
REQ-005 SHALL provide parameter FLUSH_CYCLES, default 2, legal range 1-15: flush cycles per taken branch.
REQ-006 SHALL provide these ports, one per line:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- ex_src  in  REG_AW  B-operand source register of the execute-stage instruction.
- ex_mode  in  2  B-mux select from the decoder (00 imm, 01 direct, 10 reg, 11 reserved).
- ex_dst  in  REG_AW  destination register of the execute-stage instruction.
- ex_we  in  1  execute-stage instruction writes a register.
- alu_result  in  DATA_W  ALU output of the current cycle.
- store  in  1  execute-stage instruction is a store.
- branch  in  1  branch taken this cycle.
- ram_rd_addr  in  DATA_W  RAM read address.
- ram_wr_addr  in  DATA_W  RAM write address.
- mode_out  out  2  B-mux select after override.
- fwd_data  out  DATA_W  forwarded operand.
- ram_addr  out  DATA_W  selected RAM address.
- stall  out  1  hold the fetch/decode/execute registers.
- flush  out  1  squash the younger instructions.

Function
REQ-007 SHALL hold a history of FWD_DEPTH entries {valid, dst, data}; entry 0 is the youngest.
REQ-008 SHALL shift the history on every edge where stall=0: entry 0 takes {ex_we & ~flush, ex_dst, alu_result}; entry k takes entry k-1; the oldest entry is discarded.
REQ-009 SHALL freeze the history while stall=1.
REQ-010 SHALL drive mode_out=11 and fwd_data from the youngest valid entry whose dst equals ex_src, combinationally, when ex_mode=10 and ex_src!=0.
REQ-011 SHALL pass ex_mode to mode_out and drive fwd_data=0 when no entry matches, when ex_mode!=10, or when ex_src=0.
REQ-012 SHALL implement a state machine with states IDLE, STALL and FLUSH, and a 4-bit down-counter cnt.
REQ-013 SHALL, in IDLE with branch=1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise with store=1 go to STALL with cnt=STORE_STALL-1. Branch has priority over store.
REQ-014 SHALL, in STALL, drive stall=1 and ram_addr=ram_wr_addr, decrement cnt, and return to IDLE after the cycle in which cnt=0. In STALL, branch and store are ignored.
REQ-015 SHALL, in FLUSH, drive flush=1 and decrement cnt. A branch=1 in FLUSH reloads cnt=FLUSH_CYCLES-1. Store is ignored in FLUSH. The block returns to IDLE after the cycle in which cnt=0 and branch=0.
REQ-016 SHALL, in IDLE, drive stall=0 and flush=0 registered; ram_addr=ram_wr_addr when store=1, else ram_rd_addr.
REQ-017 SHALL assert stall and flush starting the cycle after the triggering input, for exactly STORE_STALL and FLUSH_CYCLES cycles respectively, and never assert both in the same cycle.
REQ-018 SHALL compare registers as unsigned REG_AW-bit values and carry data unmodified at DATA_W bits.

Reset
REQ-019 SHALL, while rst=1, immediately force state=IDLE, cnt=0, all history valid=0, dst=0 and data=0, stall=0 and flush=0.
REQ-020 SHALL, during reset, drive mode_out=ex_mode, fwd_data=0 and ram_addr=ram_rd_addr.
REQ-021 SHALL abandon any stall or flush in progress when reset is asserted mid-operation, and SHALL accept no stale forward after reset deasserts.

Verification
REQ-022 Back-to-back forward: write r3 with alu_result=0x00000055, next cycle ex_src=3, ex_mode=10 -> mode_out=11, fwd_data=0x55.
REQ-023 Youngest-wins: with FWD_DEPTH=2, write r4=0x11 then r4=0x22, then read r4 -> fwd_data=0x22. A read of r0 after a write of r0 -> mode_out=10, fwd_data=0.
REQ-024 Store stall: STORE_STALL=3, store pulse -> stall=1 for exactly 3 cycles, ram_addr=ram_wr_addr during them, history unchanged, then stall=0.
REQ-025 Branch during flush: FLUSH_CYCLES=2, branch at t0 and again at t1 -> flush high t1..t3, low at t4. Instructions written during flush are not forwarded.
REQ-026 Simultaneous store and branch -> FLUSH entered, stall never asserted.
REQ-027 Reset mid-stall: rst pulsed in the 2nd stall cycle -> stall=0 immediately, mode_out=ex_mode, fwd_data=0 on the first read after release.
